// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide slice.
// M-extension funct3 codes, FSM encoding and operand-sign helpers.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
               (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == F3_MUL) || (op == F3_MULH) ||
               (op == F3_DIV) || (op == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final sign / special-case result select.
// Purely combinational; the iterative core works on magnitudes only.
module muldiv_sign_fix
    import rv_pkg::*;
(
    input  logic [2:0]      in_op_i,
    input  logic [XLEN-1:0] in_a_i,
    input  logic [XLEN-1:0] in_b_i,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    input  logic [2:0]      fix_op_i,
    input  logic [XLEN-1:0] fix_a_i,
    input  logic [XLEN-1:0] fix_b_i,
    input  logic [XLEN-1:0] acc_hi_i,
    input  logic [XLEN-1:0] acc_lo_i,
    output logic [XLEN-1:0] res_o
);

    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic              div_ovf;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Magnitudes of the incoming operands for the signedness of the new op
    always_comb begin
        abs_a_o = in_a_i;
        abs_b_o = in_b_i;
        if (a_is_signed(in_op_i) && in_a_i[XLEN-1]) abs_a_o = -in_a_i;
        if (b_is_signed(in_op_i) && in_b_i[XLEN-1]) abs_b_o = -in_b_i;
    end

    // Restore signs and pick the architectural result of the finished op
    always_comb begin
        a_neg    = a_is_signed(fix_op_i) && fix_a_i[XLEN-1];
        b_neg    = b_is_signed(fix_op_i) && fix_b_i[XLEN-1];
        prod     = {acc_hi_i, acc_lo_i};
        if (a_neg ^ b_neg) prod = -prod;
        quo      = (a_neg ^ b_neg) ? -acc_lo_i : acc_lo_i;
        rem      = a_neg ? -acc_hi_i : acc_hi_i;
        div_zero = (fix_b_i == '0);
        div_ovf  = ((fix_op_i == F3_DIV) || (fix_op_i == F3_REM)) &&
                   (fix_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (fix_b_i == '1);
        res_o    = '0;
        unique case (fix_op_i)
            F3_MUL:
                res_o = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:
                res_o = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:
                res_o = div_zero ? '1 :
                        div_ovf  ? {1'b1, {(XLEN-1){1'b0}}} : quo;
            F3_REM, F3_REMU:
                res_o = div_zero ? fix_a_i :
                        div_ovf  ? '0 : rem;
            default:
                res_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting behind the ID/EX register.
// Shift-add multiplier and restoring divider share one 64-bit accumulator.
module ex_muldiv_unit
    import rv_pkg::md_state_e, rv_pkg::ST_IDLE, rv_pkg::ST_CALC,
           rv_pkg::ST_FIX, rv_pkg::ST_DONE;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] res_q, res_d;

    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] fix_res;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;

    muldiv_sign_fix u_sign_fix (
        .in_op_i  (op_i),
        .in_a_i   (a_i),
        .in_b_i   (b_i),
        .abs_a_o  (abs_a),
        .abs_b_o  (abs_b),
        .fix_op_i (op_q),
        .fix_a_i  (a_q),
        .fix_b_i  (b_q),
        .acc_hi_i (hi_q),
        .acc_lo_i (lo_q),
        .res_o    (fix_res)
    );

    // Next-state, one-bit-per-cycle datapath step and handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        add_sum = {1'b0, hi_q} +
                  (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, mcand_q});
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o = 1'b1;
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    op_d    = op_i;
                    a_d     = a_i;
                    b_d     = b_i;
                    hi_d    = '0;
                    if (op_i[2]) begin
                        lo_d    = abs_a;
                        mcand_d = abs_b;
                    end else begin
                        lo_d    = abs_b;
                        mcand_d = abs_a;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        hi_d = div_ge ? XLEN'(div_sh - {1'b0, mcand_q})
                                      : div_sh[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = add_sum[XLEN:1];
                        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    res_d   = fix_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = !flush_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign result_o = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases plus random ops.
// Expected results and completion cycles come from a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
    import rv_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] last_exp = '0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      ub;
        longint      p;
        logic [63:0] up;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'b0, b});
        r   = '0;
        case (op)
            F3_MUL:    begin p = sa * sbv; r = p[31:0];  end
            F3_MULH:   begin p = sa * sbv; r = p[63:32]; end
            F3_MULHSU: begin p = sa * ub;  r = p[63:32]; end
            F3_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            F3_DIV: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = $signed(a) / $signed(b);
            end
            F3_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else r = $signed(a) % $signed(b);
            end
            F3_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            F3_REMU: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_done);
        exp_t e;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        if (expect_done) begin
            e.res = ref_model(op, a, b);
            e.due = cyc + 34;
            e.op  = op;
            e.a   = a;
            e.b   = b;
            sb.push_back(e);
            last_exp = e.res;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        wait_idle();
        issue(op, a, b, 1'b1);
        step();
        start_i = 1'b0;
        wait_idle();
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = 32'h1;
            4: v = $urandom_range(0, 20);
            5: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Scoreboard monitor: every done_o pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d got=%h exp=none",
                         cyc, result_o);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result op=%0d a=%h b=%h", e.op, e.a, e.b),
                    result_o, e.res);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        int t;
        int stall_hi;
        reset   = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_result", result_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        step();
        reset = 1'b0;
        step();

        // MUL 7 * -3: stall window and fixed latency
        t = cyc;
        issue(F3_MUL, 32'd7, 32'hFFFFFFFD, 1'b1);
        stall_hi = 0;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            if (stall_o) stall_hi++;
            step();
            if (k == 0) start_i = 1'b0;
        end
        @(negedge clk);
        chk("stall_cycles", stall_hi, 34);
        chk("stall_in_done", stall_o, 0);
        chk("done_at_t34", cyc - t, 34);
        step();
        wait_idle();
        chk("result_hold", result_o, 32'hFFFFFFEB);

        // Directed products and quotients
        run_op(F3_MULH,   32'h80000000, 32'h80000000);
        run_op(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(F3_MULHSU, 32'hFFFFFFFF, 32'h2);
        run_op(F3_DIV,    -32'd7, 32'd2);
        run_op(F3_REM,    -32'd7, 32'd2);
        run_op(F3_DIVU,   32'hFFFFFFFF, 32'h10);
        run_op(F3_REMU,   32'hFFFFFFFF, 32'h10);
        run_op(F3_DIV,    32'd5, 32'd0);
        run_op(F3_REM,    32'd5, 32'd0);
        run_op(F3_DIVU,   32'd5, 32'd0);
        run_op(F3_REMU,   32'd5, 32'd0);
        run_op(F3_DIV,    32'h80000000, 32'hFFFFFFFF);
        run_op(F3_REM,    32'h80000000, 32'hFFFFFFFF);

        // Flush mid-divide: no completion, result kept, restart latency
        wait_idle();
        t = cyc;
        issue(F3_DIVU, 32'd1000, 32'd7, 1'b0);
        step();
        start_i = 1'b0;
        while (cyc < t + 10) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy_o, 0);
        chk("flush_stall", stall_o, 0);
        chk("flush_result", result_o, last_exp);
        step();
        chk("restart_cycle", cyc - t, 12);
        issue(F3_REMU, 32'd1000, 32'd7, 1'b1);
        step();
        start_i = 1'b0;
        wait_idle();

        // Flush together with start in IDLE: nothing accepted
        issue(F3_MUL, 32'd3, 32'd3, 1'b0);
        flush_i = 1'b1;
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", busy_o, 0);
        step();

        // start_i held through CALC/FIX/DONE completes exactly once
        issue(F3_MUL, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        repeat (34) step();
        start_i = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("held_start_once", busy_o, 0);
        step();

        // Reset in the middle of a MUL
        t = cyc;
        issue(F3_MUL, 32'd99, 32'd77, 1'b0);
        step();
        start_i = 1'b0;
        while (cyc < t + 20) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_result", result_o, 0);
        step();
        reset = 1'b0;
        last_exp = '0;
        step();

        // Random ops against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            run_op(rop, rnd_operand(), rnd_operand());
        end

        wait_idle();
        step();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
